// File: rtl/fir_filter_seq_if.sv
// Sample, result and coefficient-port bundle for fir_filter_seq.
// The filter takes the slave modport; the sample source / controller takes master.
interface fir_filter_seq_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned COEF_W = 16,
   parameter int unsigned TAPS   = 15
);
   localparam int unsigned AW = $clog2(TAPS);

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_sample;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_sample;
   logic                     coef_we;
   logic        [AW-1:0]     coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic                     busy;

   modport master (
      output in_valid, in_sample, out_ready, coef_we, coef_addr, coef_data,
      input  in_ready, out_valid, out_sample, busy
   );

   modport slave (
      input  in_valid, in_sample, out_ready, coef_we, coef_addr, coef_data,
      output in_ready, out_valid, out_sample, busy
   );
endinterface

// File: rtl/fir_filter_seq.sv
// Time-multiplexed FIR: one signed MAC walks TAPS coefficients per accepted sample.
// Define FIR_SAT_EN to saturate the output; otherwise the output wraps to DATA_W bits.
module fir_filter_seq #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned COEF_W = 16,
   parameter int unsigned TAPS   = 15,
   parameter int unsigned FRAC   = 15
) (
   input logic            clk_i,
   input logic            rst_i,
   fir_filter_seq_if.slave bus
);
   localparam int unsigned AW     = $clog2(TAPS);
   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
   localparam logic [AW-1:0] LastIdx = AW'(TAPS - 1);

   typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

   state_e                   state_q, state_d;
   logic signed [DATA_W-1:0] delay_q [TAPS];
   logic signed [DATA_W-1:0] delay_d [TAPS];
   logic signed [COEF_W-1:0] coef_q  [TAPS];
   logic signed [COEF_W-1:0] coef_d  [TAPS];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic        [AW-1:0]     idx_q, idx_d;
   logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
   logic                     out_valid_q, out_valid_d;

   logic                     accept, coef_wr, mac_last;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_sum, shifted;
   logic signed [DATA_W-1:0] fmt_val;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.in_valid)     state_d = StMac;
         StMac:   if (idx_q == LastIdx) state_d = StOut;
         StOut:   if (bus.out_ready)    state_d = StIdle;
         default:                       state_d = StIdle;
      endcase
   end

   // Outputs and datapath strobes decoded from state
   always_comb begin
      bus.in_ready = (state_q == StIdle);
      bus.busy     = (state_q != StIdle);
      accept       = (state_q == StIdle) && bus.in_valid;
      coef_wr      = (state_q == StIdle) && bus.coef_we && (bus.coef_addr <= LastIdx);
      mac_last     = (state_q == StMac) && (idx_q == LastIdx);
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_sample = out_sample_q;

   assign prod    = coef_q[idx_q] * delay_q[idx_q];
   assign acc_sum = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
   assign shifted = acc_sum >>> FRAC;

`ifdef FIR_SAT_EN
   localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

   always_comb begin
      if (shifted > SatMax) begin
         fmt_val = SatMax[DATA_W-1:0];
      end else if (shifted < SatMin) begin
         fmt_val = SatMin[DATA_W-1:0];
      end else begin
         fmt_val = shifted[DATA_W-1:0];
      end
   end
`else
   logic unused_shifted_hi;
   assign unused_shifted_hi = ^shifted[ACC_W-1:DATA_W];
   assign fmt_val = shifted[DATA_W-1:0];
`endif

   always_comb begin
      delay_d      = delay_q;
      coef_d       = coef_q;
      acc_d        = acc_q;
      idx_d        = idx_q;
      out_sample_d = out_sample_q;
      out_valid_d  = out_valid_q;
      // A same-cycle coefficient write lands before the MAC pass that uses it
      if (coef_wr) begin
         coef_d[bus.coef_addr] = bus.coef_data;
      end
      if (accept) begin
         delay_d[0] = bus.in_sample;
         for (int i = 1; i < TAPS; i++) begin
            delay_d[i] = delay_q[i-1];
         end
         acc_d = '0;
         idx_d = '0;
      end
      if (state_q == StMac) begin
         acc_d = acc_sum;
         idx_d = mac_last ? idx_q : idx_q + 1'b1;
         if (mac_last) begin
            out_sample_d = fmt_val;
            out_valid_d  = 1'b1;
         end
      end
      if ((state_q == StOut) && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < TAPS; i++) begin
            delay_q[i] <= '0;
            coef_q[i]  <= '0;
         end
         acc_q        <= '0;
         idx_q        <= '0;
         out_sample_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         delay_q      <= delay_d;
         coef_q       <= coef_d;
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         out_sample_q <= out_sample_d;
         out_valid_q  <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_fir_filter_seq.sv
// Self-checking bench for fir_filter_seq: directed tables, corner sequences and random
// traffic against a plain-arithmetic convolution model.
module tb_fir_filter_seq;
   localparam int DW   = 16;
   localparam int CW   = 16;
   localparam int TAPS = 15;
   localparam int FRAC = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fir_filter_seq_if #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS)) bus ();

   fir_filter_seq #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .FRAC(FRAC)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: sample history since reset and the coefficient table
   longint m_hist [TAPS];
   longint m_coef [TAPS];

   typedef struct {
      longint sample;
      longint expect_out;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint model_out();
      longint acc = 0;
      logic signed [DW-1:0] w;
      for (int i = 0; i < TAPS; i++) acc += m_coef[i] * m_hist[i];
      acc = acc >>> FRAC;
`ifdef FIR_SAT_EN
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      return acc;
`else
      w = acc[DW-1:0];
      return longint'(w);
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < TAPS; i++) begin
         m_hist[i] = 0;
         m_coef[i] = 0;
      end
   endtask

   task automatic model_write(input int addr, input longint data);
      if (addr < TAPS) m_coef[addr] = data;
   endtask

   task automatic model_accept(input longint x);
      for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = x;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic idle_write(input int addr, input longint data);
      logic [CW-1:0] d;
      d = data[CW-1:0];
      bus.coef_we   = 1'b1;
      bus.coef_addr = addr[3:0];
      bus.coef_data = d;
      tick();
      bus.coef_we = 1'b0;
      model_write(addr, data);
   endtask

   // Push one sample (optionally with a same-cycle or mid-MAC coefficient write),
   // check latency, return the result and pop it.
   task automatic run_sample(input longint x, input bit same_wr, input bit mac_wr,
                             input int waddr, input longint wdata, output longint y);
      int lat;
      logic [CW-1:0] d;
      d = wdata[CW-1:0];
      check("in_ready_idle", longint'(bus.in_ready), 1);
      bus.in_valid  = 1'b1;
      bus.in_sample = x[DW-1:0];
      if (same_wr) begin
         bus.coef_we   = 1'b1;
         bus.coef_addr = waddr[3:0];
         bus.coef_data = d;
         model_write(waddr, wdata);
      end
      tick();
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
      model_accept(x);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         if (mac_wr && lat == 3) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = waddr[3:0];
            bus.coef_data = d;
         end else begin
            bus.coef_we = 1'b0;
         end
         tick();
         lat++;
      end
      bus.coef_we = 1'b0;
      check("latency", longint'(lat), TAPS);
      y = longint'($signed(bus.out_sample));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("out_valid_drop", longint'(bus.out_valid), 0);
   endtask

   initial begin
      vec_t   tbl [TAPS];
      longint y, held;
      int     lat, seen;

      bus.in_valid  = 1'b0;
      bus.in_sample = '0;
      bus.out_ready = 1'b0;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();

      check("rst_out_valid", longint'(bus.out_valid), 0);
      check("rst_out_sample", longint'($signed(bus.out_sample)), 0);
      check("rst_in_ready", longint'(bus.in_ready), 1);
      check("rst_busy", longint'(bus.busy), 0);

      // Single-tap unity-ish gain
      idle_write(0, 32767);
      run_sample(1000, 1'b0, 1'b0, 0, 0, y);
      check("t1_out", y, 999);

      // Impulse through a ramp of coefficients
      do_reset();
      for (int k = 0; k < TAPS; k++) begin
         tbl[k].sample     = (k == 0) ? 32767 : 0;
         tbl[k].expect_out = (k == 0) ? 0 : 100 * k - 1;
         idle_write(k, 100 * k);
      end
      for (int k = 0; k < TAPS; k++) begin
         run_sample(tbl[k].sample, 1'b0, 1'b0, 0, 0, y);
         check($sformatf("t2_out[%0d]", k), y, tbl[k].expect_out);
         check($sformatf("t2_model[%0d]", k), y, model_out());
      end

      // Overflow: full-scale negative input into all-max coefficients
      do_reset();
      for (int k = 0; k < TAPS; k++) idle_write(k, 32767);
      for (int k = 0; k < TAPS; k++) begin
         run_sample(-32768, 1'b0, 1'b0, 0, 0, y);
         check($sformatf("t3_model[%0d]", k), y, model_out());
      end
`ifdef FIR_SAT_EN
      check("t3_last", y, -32768);
`else
      check("t3_last", y, -32753);
`endif

      // Backpressure in OUT: result held, in_valid pulses dropped
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'sd500;
      tick();
      bus.in_valid = 1'b0;
      model_accept(500);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("t4_latency", longint'(lat), TAPS);
      held = longint'($signed(bus.out_sample));
      check("t4_out", held, model_out());
      for (int c = 0; c < 10; c++) begin
         bus.in_valid  = c[0];
         bus.in_sample = 16'sd12345;
         tick();
         check("t4_valid_hold", longint'(bus.out_valid), 1);
         check("t4_sample_hold", longint'($signed(bus.out_sample)), held);
         check("t4_in_ready", longint'(bus.in_ready), 0);
         check("t4_busy", longint'(bus.busy), 1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      run_sample(-700, 1'b0, 1'b0, 0, 0, y);
      check("t4_after", y, model_out());

      // Reset in the middle of a MAC pass
      do_reset();
      idle_write(0, 20000);
      idle_write(1, -15000);
      run_sample(5000, 1'b0, 1'b0, 0, 0, y);
      check("t5_pre", y, model_out());
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'sd7000;
      tick();
      bus.in_valid = 1'b0;
      for (int c = 0; c < 7; c++) tick();
      do_reset();
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.out_valid) seen++;
         tick();
      end
      check("t5_no_valid", longint'(seen), 0);
      check("t5_in_ready", longint'(bus.in_ready), 1);
      run_sample(1234, 1'b0, 1'b0, 0, 0, y);
      check("t5_zeroed", y, 0);

      // Coefficient write ignored mid-MAC, honoured with a same-cycle accept
      run_sample(1000, 1'b0, 1'b1, 0, 5000, y);
      check("t6_mac_wr", y, 0);
      run_sample(1000, 1'b1, 1'b0, 0, 5000, y);
      check("t6_idle_wr", y, 152);
      check("t6_model", y, model_out());

      // Random traffic, including writes to the out-of-range address
      do_reset();
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            idle_write(int'($urandom_range(0, 15)), longint'($urandom_range(0, 65535)) - 32768);
         end
         run_sample(longint'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                    longint'($urandom_range(0, 65535)) - 32768, y);
         check($sformatf("rand[%0d]", n), y, model_out());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
